// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction fetch front end buffering fetched instructions in a DEPTH-entry FIFO.
// Define IF_ACK_BYPASS_EN to hand an ack straight to decode when the FIFO is empty.
module if_prefetch_queue #(
    parameter int XLEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    o_Imem_stb,
    output logic [XLEN-1:0]         o_Iaddr,
    input  logic                    i_Imem_ack,
    input  logic [31:0]             i_Inst,
    input  logic                    i_Redirect,
    input  logic [XLEN-1:0]         i_Target,
    input  logic                    i_Stall,
    output logic                    o_ValidD,
    output logic [31:0]             o_InstrD,
    output logic [XLEN-1:0]         o_PcD,
    output logic [$clog2(DEPTH):0]  o_Count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    state_t state;
    logic [XLEN-1:0] fetch_pc, drain_addr;
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [31:0] inst_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count, next_count;
    logic take, bypass, push, pop;
    assign take = state == REQ && i_Imem_ack && !i_Redirect;
`ifdef IF_ACK_BYPASS_EN
    assign bypass = take && count == '0;
`else
    assign bypass = 1'b0;
`endif
    // A bypassed instruction consumed by decode never enters the FIFO.
    assign push = take && !(bypass && !i_Stall);
    assign pop = count != '0 && !i_Stall && !i_Redirect;
    assign next_count = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign o_Imem_stb = state != IDLE;
    assign o_Iaddr = state == DRAIN ? drain_addr : fetch_pc;
    assign o_Count = count;
    assign o_ValidD = count != '0 || bypass;
    assign o_InstrD = count != '0 ? inst_mem[rd_ptr] : bypass ? i_Inst : NOP;
    assign o_PcD = count != '0 ? pc_mem[rd_ptr] : bypass ? fetch_pc : '0;
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr] <= fetch_pc;
            inst_mem[wr_ptr] <= i_Inst;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fetch_pc <= RESET_PC;
            drain_addr <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (i_Redirect) begin
            fetch_pc <= i_Target & ~XLEN'(3);
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            // An unacked request must still be drained; its address stays on the bus.
            if (state == REQ && !i_Imem_ack) begin
                state <= DRAIN;
                drain_addr <= fetch_pc;
            end else if (i_Imem_ack) begin
                state <= IDLE;
            end
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= next_count;
            if (take)
                fetch_pc <= fetch_pc + XLEN'(4);
            case (state)
                IDLE: if (count < FULL) state <= REQ;
                REQ: if (take && next_count >= FULL) state <= IDLE;
                default: if (i_Imem_ack) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed and randomized checks of if_prefetch_queue against a queue-based model.
module tb_if_prefetch_queue;
    localparam int XLEN = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ACK_BYPASS_EN
    localparam int FIRST_VALID = 2;
`else
    localparam int FIRST_VALID = 3;
`endif
    logic clk = 0, rst_n = 0;
    logic o_Imem_stb, i_Imem_ack, i_Redirect, i_Stall, o_ValidD;
    logic [31:0] o_Iaddr, i_Inst, i_Target, o_InstrD, o_PcD;
    logic [2:0] o_Count;
    always #5 clk = ~clk;

    if_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .o_Imem_stb(o_Imem_stb), .o_Iaddr(o_Iaddr),
        .i_Imem_ack(i_Imem_ack), .i_Inst(i_Inst), .i_Redirect(i_Redirect),
        .i_Target(i_Target), .i_Stall(i_Stall), .o_ValidD(o_ValidD),
        .o_InstrD(o_InstrD), .o_PcD(o_PcD), .o_Count(o_Count)
    );

    int total = 0, bad = 0;
    typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;
    ent_t q[$];
    logic [31:0] m_pc, m_daddr;
    bit m_busy, m_drain;
    int lat, lat_fix = 0, lat_max = 0, stall_pct = 0, redir_pct = 0, spurious = 0;
    bit rnd_inst = 0, force_redir = 0;
    logic [31:0] force_tgt;
    logic s_stb, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;
    logic [2:0] s_count;
    logic [31:0] f_pc, f_addr;
    logic [31:0] got[$];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    function automatic int pick();
        return lat_fix >= 0 ? lat_fix : int'($urandom_range(lat_max));
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc = RESET_PC;
        m_busy = 0;
        m_drain = 0;
        lat = pick();
    endtask

    task automatic do_reset();
        rst_n = 0;
        i_Imem_ack = 0; i_Redirect = 0; i_Stall = 0; i_Inst = 0; i_Target = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    // One cycle: drive from the memory/decode model at negedge, compare, then advance the model.
    task automatic step();
        logic byp, ev, pop;
        logic [31:0] ei, ep, addr;
        int cnt0;
        addr = m_drain ? m_daddr : m_pc;
        if (m_busy) begin
            i_Imem_ack = lat == 0;
            lat = lat == 0 ? pick() : lat - 1;
        end else begin
            i_Imem_ack = $urandom_range(99) < spurious;
        end
        i_Inst = rnd_inst ? $urandom : addr ^ 32'hA5A5_0000;
        i_Redirect = force_redir || ($urandom_range(99) < redir_pct);
        i_Target = force_redir ? force_tgt : $urandom;
        force_redir = 0;
        i_Stall = $urandom_range(99) < stall_pct;
        #1;
        byp = 0;
`ifdef IF_ACK_BYPASS_EN
        byp = q.size() == 0 && m_busy && !m_drain && i_Imem_ack && !i_Redirect;
`endif
        ev = q.size() != 0 || byp;
        ei = q.size() != 0 ? q[0].inst : byp ? i_Inst : NOP;
        ep = q.size() != 0 ? q[0].pc : byp ? m_pc : 32'h0;
        chk("stb", o_Imem_stb, m_busy);
        if (m_busy) chk("addr", o_Iaddr, addr);
        chk("valid", o_ValidD, ev);
        chk("instr", o_InstrD, ei);
        chk("pc", o_PcD, ep);
        chk("count", o_Count, q.size());
        s_stb = o_Imem_stb; s_addr = o_Iaddr; s_valid = o_ValidD;
        s_pc = o_PcD; s_inst = o_InstrD; s_count = o_Count;
        @(posedge clk);
        cnt0 = q.size();
        pop = cnt0 != 0 && !i_Stall && !i_Redirect;
        if (i_Redirect) begin
            q.delete();
            if (m_busy && !m_drain && !i_Imem_ack) begin
                m_drain = 1;
                m_daddr = m_pc;
            end else if (m_busy && i_Imem_ack) begin
                m_busy = 0;
                m_drain = 0;
            end
            m_pc = i_Target & ~32'h3;
        end else begin
            if (pop) void'(q.pop_front());
            if (!m_busy) begin
                m_busy = cnt0 < DEPTH;
            end else if (m_drain) begin
                if (i_Imem_ack) begin m_busy = 0; m_drain = 0; end
            end else if (i_Imem_ack) begin
                if (!(byp && !i_Stall)) q.push_back({m_pc, i_Inst});
                m_pc += 4;
                if (q.size() >= DEPTH) m_busy = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_obs(input int n);
        f_pc = 32'hFFFF_FFFF;
        f_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            step();
            if (s_valid && f_pc == 32'hFFFF_FFFF) f_pc = s_pc;
            if (s_stb && f_addr == 32'hFFFF_FFFF) f_addr = s_addr;
        end
    endtask

    initial begin
        int first;
        int cfg[4][4] = '{'{0, 0, 0, 0}, '{30, 5, 3, 10}, '{70, 2, 2, 0}, '{20, 15, 1, 20}};
        i_Imem_ack = 0; i_Redirect = 0; i_Stall = 0; i_Inst = 0; i_Target = 0;
        // Reset values and basic streaming with one-cycle ack latency
        repeat (2) @(negedge clk);
        chk("rst_stb", o_Imem_stb, 0);
        chk("rst_valid", o_ValidD, 0);
        chk("rst_instr", o_InstrD, NOP);
        chk("rst_pc", o_PcD, 0);
        chk("rst_count", o_Count, 0);
        lat_fix = 1;
        rst_n = 1;
        model_reset();
        first = -1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (s_valid) begin
                if (first < 0) first = k;
                got.push_back(s_pc);
                got.push_back(s_inst);
            end
        end
        chk("first_valid_cycle", first, FIRST_VALID);
        for (int i = 0; i < 3; i++) begin
            chk("stream_pc", got.size() > 2*i ? got[2*i] : 32'hFFFF_FFFF, 4*i);
            chk("stream_inst", got.size() > 2*i+1 ? got[2*i+1] : 32'hFFFF_FFFF, (4*i) ^ 32'hA5A5_0000);
        end
        // Stall until full, then drain in order
        lat_fix = 0;
        stall_pct = 100;
        do_reset();
        repeat (10) step();
        chk("full_count", s_count, 4);
        chk("full_stb", s_stb, 0);
        chk("full_head", s_pc, 0);
        stall_pct = 0;
        got.delete();
        for (int k = 0; k < 8; k++) begin
            step();
            if (s_valid) got.push_back(s_pc);
        end
        for (int i = 0; i < 5; i++) chk("drain_order", got.size() > i ? got[i] : 32'hFFFF_FFFF, 4*i);
        // Redirect while idle with a full FIFO
        stall_pct = 100;
        repeat (10) step();
        chk("idle_full_count", s_count, 4);
        force_redir = 1; force_tgt = 32'h103;
        step();
        stall_pct = 0;
        step();
        chk("redir_flush_count", s_count, 0);
        chk("redir_flush_valid", s_valid, 0);
        run_obs(5);
        chk("redir_idle_addr", f_addr, 32'h100);
        chk("redir_idle_pc", f_pc, 32'h100);
        // Redirect while a request to 0x8 waits for its ack
        do_reset();
        step(); step();
        lat_fix = 3;
        step(); step();
        force_redir = 1; force_tgt = 32'h200;
        step();
        step();
        chk("drain_stb", s_stb, 1);
        chk("drain_addr", s_addr, 32'h8);
        lat_fix = 0;
        step();
        chk("drain_ack_addr", s_addr, 32'h8);
        step();
        chk("drain_done_stb", s_stb, 0);
        run_obs(6);
        chk("after_drain_addr", f_addr, 32'h200);
        chk("after_drain_pc", f_pc, 32'h200);
        // Redirect in the same cycle as the ack for 0x8
        stall_pct = 100;
        do_reset();
        step(); step(); step();
        force_redir = 1; force_tgt = 32'h40;
        step();
        chk("ack_redir_addr", s_addr, 32'h8);
        step();
        chk("ack_redir_count", s_count, 0);
        chk("ack_redir_stb", s_stb, 0);
        step();
        chk("ack_redir_next", s_addr, 32'h40);
        // Asynchronous reset mid-request
        do_reset();
        step(); step(); step();
        #2;
        chk("pre_rst_stb", o_Imem_stb, 1);
        chk("pre_rst_count", o_Count, 2);
        rst_n = 0;
        #1;
        chk("async_rst_stb", o_Imem_stb, 0);
        chk("async_rst_valid", o_ValidD, 0);
        chk("async_rst_count", o_Count, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        step();
        step();
        chk("post_rst_addr", s_addr, RESET_PC);
        // Randomized traffic
        lat_fix = -1;
        rnd_inst = 1;
        for (int p = 0; p < 4; p++) begin
            stall_pct = cfg[p][0]; redir_pct = cfg[p][1]; lat_max = cfg[p][2]; spurious = cfg[p][3];
            do_reset();
            repeat (2500) step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
